// File: rtl/gpcfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpcfg_pkg
// Brief   : Shared constants, types and sizing helpers for the gpcfg
//           read-data reduction tree.
// Revision: 1.0 - initial release
// ============================================================================
package gpcfg_pkg;

    localparam int GPCFG_DW = 32;

    typedef logic [GPCFG_DW-1:0] gpcfg_word_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Sources per first-stage group; the last group takes the remainder.
    function automatic int grp_size(input int num_src, input int num_groups);
        return (num_src + num_groups - 1) / num_groups;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpcfg_rdata_grp.sv
`default_nettype none
// ============================================================================
// Module  : gpcfg_rdata_grp
// Brief   : One first-stage group: hit-gated OR of SRC_N source words into a
//           register that clears whenever valid_rd is low. With
//           GPCFG_RDATA_COLL_CHK_EN it also reports its hit count saturated
//           at 2.
// Revision: 1.0 - initial release
// ============================================================================
module gpcfg_rdata_grp
    import gpcfg_pkg::*;
#(
    parameter int SRC_LO   = 0,
    parameter int SRC_N    = 1,
    parameter int DW       = GPCFG_DW,
    parameter int HIT_GATE = 1
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic [SRC_N*DW-1:0] rdata,
    input  logic [SRC_N-1:0]    rd_hit,
    input  logic                valid_rd,
`ifdef GPCFG_RDATA_COLL_CHK_EN
    output logic [1:0]          grp_hits,
`endif
    output logic [DW-1:0]       grp_data
);

    if (SRC_N < 1 || SRC_LO < 0) begin : g_bad_cfg
        $error("gpcfg_rdata_grp: illegal SRC_LO/SRC_N");
    end

    logic [DW-1:0] w_or;
    logic [DW-1:0] r_data;

    always_comb begin
        w_or = '0;
        for (int i = 0; i < SRC_N; i++) begin
            if (HIT_GATE != 0)
                w_or = w_or | (rdata[i*DW +: DW] & {DW{rd_hit[i]}});
            else
                w_or = w_or | rdata[i*DW +: DW];
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            r_data <= '0;
        else
            r_data <= valid_rd ? w_or : '0;
    end

    assign grp_data = r_data;

`ifdef GPCFG_RDATA_COLL_CHK_EN
    // Saturating at 2 is enough to tell "none", "one" and "several".
    logic [1:0] w_cnt;

    always_comb begin
        w_cnt = 2'd0;
        for (int i = 0; i < SRC_N; i++) begin
            if (rd_hit[i] && (w_cnt != 2'd2))
                w_cnt = w_cnt + 2'd1;
        end
    end

    assign grp_hits = w_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/gpcfg_rdata_tree.sv
`default_nettype none
// ============================================================================
// Module  : gpcfg_rdata_tree
// Brief   : Pipelined OR-reduction of NUM_SRC register read words into one
//           AHB hrdata word with aligned valid strobe. Collision detection
//           is built only when GPCFG_RDATA_COLL_CHK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module gpcfg_rdata_tree
    import gpcfg_pkg::*;
#(
    parameter int NUM_SRC    = 1024,
    parameter int DW         = GPCFG_DW,
    parameter int NUM_GROUPS = 4,
    parameter int HIT_GATE   = 1,
    parameter int OUT_REG    = 0,
    parameter int CNT_W      = 8
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [NUM_SRC*DW-1:0] rdata,
    input  logic [NUM_SRC-1:0]    rd_hit,
    input  logic                  valid_rd,
    input  logic                  err_clr,
    output logic [DW-1:0]         hrdata,
    output logic                  hrdata_vld,
    output logic                  coll_err,
    output logic                  coll_sticky,
    output logic [CNT_W-1:0]      coll_cnt
);

    localparam int GRP = grp_size(NUM_SRC, NUM_GROUPS);

    if (NUM_GROUPS > NUM_SRC || NUM_GROUPS < 1) begin : g_bad_cfg
        $error("gpcfg_rdata_tree: NUM_GROUPS must be in 1..NUM_SRC");
    end

    logic [NUM_GROUPS-1:0][DW-1:0] w_grp_data;
    logic [DW-1:0]                 w_final;
    logic                          r_vld_a;
`ifdef GPCFG_RDATA_COLL_CHK_EN
    logic [NUM_GROUPS-1:0][1:0]    w_grp_hits;
`endif

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        localparam int c_lo = g * GRP;
        localparam int c_n  = (c_lo + GRP <= NUM_SRC) ? GRP : NUM_SRC - c_lo;
        // Rounding up the group size can leave trailing groups with no sources.
        if (c_lo < NUM_SRC) begin : g_src
            gpcfg_rdata_grp #(
                .SRC_LO   (c_lo),
                .SRC_N    (c_n),
                .DW       (DW),
                .HIT_GATE (HIT_GATE)
            ) u_grp (
                .hclk     (hclk),
                .hreset   (hreset),
                .rdata    (rdata[c_lo*DW +: c_n*DW]),
                .rd_hit   (rd_hit[c_lo +: c_n]),
                .valid_rd (valid_rd),
`ifdef GPCFG_RDATA_COLL_CHK_EN
                .grp_hits (w_grp_hits[g]),
`endif
                .grp_data (w_grp_data[g])
            );
        end else begin : g_empty
            assign w_grp_data[g] = '0;
`ifdef GPCFG_RDATA_COLL_CHK_EN
            assign w_grp_hits[g] = 2'd0;
`endif
        end
    end

    always_comb begin
        w_final = '0;
        for (int g = 0; g < NUM_GROUPS; g++)
            w_final = w_final | w_grp_data[g];
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            r_vld_a <= 1'b0;
        else
            r_vld_a <= valid_rd;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] r_data_o;
        logic          r_vld_o;

        always_ff @(posedge hclk or posedge hreset) begin
            if (hreset) begin
                r_data_o <= '0;
                r_vld_o  <= 1'b0;
            end else begin
                r_data_o <= w_final;
                r_vld_o  <= r_vld_a;
            end
        end

        assign hrdata     = r_data_o;
        assign hrdata_vld = r_vld_o;
    end else begin : g_out_comb
        assign hrdata     = w_final;
        assign hrdata_vld = r_vld_a;
    end

`ifdef GPCFG_RDATA_COLL_CHK_EN
    localparam int c_sum_w = (clog2(2 * NUM_GROUPS + 1) < 2) ? 2 : clog2(2 * NUM_GROUPS + 1);

    logic [c_sum_w-1:0] w_hit_sum;
    logic               w_coll_det;
    logic               r_coll_a;
    logic               w_coll_evt;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_cnt;

    always_comb begin
        w_hit_sum = '0;
        for (int g = 0; g < NUM_GROUPS; g++)
            w_hit_sum = w_hit_sum + c_sum_w'(w_grp_hits[g]);
    end

    assign w_coll_det = valid_rd && (w_hit_sum > c_sum_w'(1));

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            r_coll_a <= 1'b0;
        else
            r_coll_a <= w_coll_det;
    end

    // w_coll_evt is the value coll_err takes at the coming edge, so the
    // sticky bit and counter move together with the visible pulse.
    if (OUT_REG != 0) begin : g_coll_reg
        logic r_coll_o;

        always_ff @(posedge hclk or posedge hreset) begin
            if (hreset)
                r_coll_o <= 1'b0;
            else
                r_coll_o <= r_coll_a;
        end

        assign w_coll_evt = r_coll_a;
        assign coll_err   = r_coll_o;
    end else begin : g_coll_comb
        assign w_coll_evt = w_coll_det;
        assign coll_err   = r_coll_a;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_coll_evt) begin
            r_sticky <= 1'b1;
            if (err_clr)
                r_cnt <= CNT_W'(1);
            else if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + CNT_W'(1);
        end else if (err_clr) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end
    end

    assign coll_sticky = r_sticky;
    assign coll_cnt    = r_cnt;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign coll_err         = 1'b0;
    assign coll_sticky      = 1'b0;
    assign coll_cnt         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpcfg_rdata_tree.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpcfg_rdata_tree
// Brief   : Three differently configured trees share one stimulus stream and
//           are compared every cycle against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpcfg_rdata_tree;

    localparam int NS = 10;
    localparam int DW = 32;
`ifdef GPCFG_RDATA_COLL_CHK_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    // Instance 0: NG=4 HG=1 OUT_REG=0 CNT_W=2
    // Instance 1: NG=3 HG=0 OUT_REG=1 CNT_W=8
    // Instance 2: NG=6 HG=1 OUT_REG=1 CNT_W=8 (last group empty)
    localparam bit HG   [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit OREG [3] = '{1'b0, 1'b1, 1'b1};
    localparam int CMAX [3] = '{3, 255, 255};

    logic             hclk;
    logic             hreset;
    logic [NS*DW-1:0] rdata;
    logic [NS-1:0]    rd_hit;
    logic             valid_rd;
    logic             err_clr;

    logic [DW-1:0] o_data   [3];
    logic          o_vld    [3];
    logic          o_coll   [3];
    logic          o_sticky [3];
    logic [1:0]    cnt0;
    logic [7:0]    cnt1;
    logic [7:0]    cnt2;

    gpcfg_rdata_tree #(.NUM_SRC(NS), .DW(DW), .NUM_GROUPS(4), .HIT_GATE(1), .OUT_REG(0), .CNT_W(2)) dut0 (
        .hclk(hclk), .hreset(hreset), .rdata(rdata), .rd_hit(rd_hit), .valid_rd(valid_rd),
        .err_clr(err_clr), .hrdata(o_data[0]), .hrdata_vld(o_vld[0]), .coll_err(o_coll[0]),
        .coll_sticky(o_sticky[0]), .coll_cnt(cnt0));

    gpcfg_rdata_tree #(.NUM_SRC(NS), .DW(DW), .NUM_GROUPS(3), .HIT_GATE(0), .OUT_REG(1), .CNT_W(8)) dut1 (
        .hclk(hclk), .hreset(hreset), .rdata(rdata), .rd_hit(rd_hit), .valid_rd(valid_rd),
        .err_clr(err_clr), .hrdata(o_data[1]), .hrdata_vld(o_vld[1]), .coll_err(o_coll[1]),
        .coll_sticky(o_sticky[1]), .coll_cnt(cnt1));

    gpcfg_rdata_tree #(.NUM_SRC(NS), .DW(DW), .NUM_GROUPS(6), .HIT_GATE(1), .OUT_REG(1), .CNT_W(8)) dut2 (
        .hclk(hclk), .hreset(hreset), .rdata(rdata), .rd_hit(rd_hit), .valid_rd(valid_rd),
        .err_clr(err_clr), .hrdata(o_data[2]), .hrdata_vld(o_vld[2]), .coll_err(o_coll[2]),
        .coll_sticky(o_sticky[2]), .coll_cnt(cnt2));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: visible outputs plus the one result still in flight
    // for the instances with the extra output stage.
    logic [DW-1:0] m_data   [3];
    bit            m_vld    [3];
    bit            m_coll   [3];
    bit            m_sticky [3];
    int            m_cnt    [3];
    logic [DW-1:0] p_data   [3];
    bit            p_vld;
    bit            p_coll;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d]: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
    endtask

    task automatic check_all();
        logic [31:0] c;
        for (int k = 0; k < 3; k++) begin
            c = (k == 0) ? {30'd0, cnt0} : (k == 1) ? {24'd0, cnt1} : {24'd0, cnt2};
            chk("hrdata",      k, o_data[k],          m_data[k]);
            chk("hrdata_vld",  k, {31'd0, o_vld[k]},    {31'd0, m_vld[k]});
            chk("coll_err",    k, {31'd0, o_coll[k]},   {31'd0, m_coll[k]});
            chk("coll_sticky", k, {31'd0, o_sticky[k]}, {31'd0, m_sticky[k]});
            chk("coll_cnt",    k, c,                    m_cnt[k]);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_data[k] = '0; m_vld[k] = 0; m_coll[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
            p_data[k] = '0;
        end
        p_vld  = 0;
        p_coll = 0;
    endtask

    // One clock: sample the applied inputs, advance the model, check after the edge.
    task automatic tick();
        logic [DW-1:0] gated, ungated, cur, nd;
        bit v, c, clr, nv, nc;
        v = valid_rd;
        clr = err_clr;
        gated = '0;
        ungated = '0;
        for (int i = 0; i < NS; i++) begin
            ungated |= rdata[i*DW +: DW];
            if (rd_hit[i]) gated |= rdata[i*DW +: DW];
        end
        if (!v) begin
            gated = '0;
            ungated = '0;
        end
        c = COLL_EN && v && ($countones(rd_hit) > 1);
        @(posedge hclk);
        for (int k = 0; k < 3; k++) begin
            cur = HG[k] ? gated : ungated;
            if (OREG[k]) begin
                nd = p_data[k]; nv = p_vld; nc = p_coll;
            end else begin
                nd = cur; nv = v; nc = c;
            end
            p_data[k] = cur;
            m_data[k] = nd;
            m_vld[k]  = nv;
            m_coll[k] = nc;
            if (nc) begin
                m_sticky[k] = 1;
                m_cnt[k] = clr ? 1 : ((m_cnt[k] < CMAX[k]) ? m_cnt[k] + 1 : CMAX[k]);
            end else if (clr) begin
                m_sticky[k] = 0;
                m_cnt[k] = 0;
            end
        end
        p_vld  = v;
        p_coll = c;
        #1;
        check_all();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NS; i++) rdata[i*DW +: DW] = $urandom;
    endtask

    task automatic idle();
        valid_rd = 1'b0;
        rd_hit   = '0;
        err_clr  = 1'b0;
    endtask

    initial begin
        hreset = 1'b1;
        idle();
        rand_data();
        model_clear();
        #1;
        check_all();
        repeat (2) @(posedge hclk);
        #1;
        check_all();
        @(negedge hclk);
        hreset = 1'b0;
        tick();

        // Single read of source 5, then an idle cycle
        rand_data();
        rdata[5*DW +: DW] = 32'hA5A5_0001;
        rd_hit = 10'h020; valid_rd = 1'b1;
        tick();
        idle();
        tick();
        tick();

        // Back-to-back reads of sources 0, 3, 7
        rand_data();
        rdata[0*DW +: DW] = 32'h1;
        rdata[3*DW +: DW] = 32'h30;
        rdata[7*DW +: DW] = 32'h700;
        valid_rd = 1'b1;
        rd_hit = 10'h001; tick();
        rd_hit = 10'h008; tick();
        rd_hit = 10'h080; tick();
        idle();
        tick();
        tick();

        // Unmapped read with all sources all-ones
        for (int i = 0; i < NS; i++) rdata[i*DW +: DW] = 32'hFFFF_FFFF;
        valid_rd = 1'b1;
        tick();
        idle();
        tick();
        tick();

        // Two-source collision
        rand_data();
        rdata[0*DW +: DW] = 32'h10;
        rdata[1*DW +: DW] = 32'h01;
        rd_hit = 10'h003; valid_rd = 1'b1;
        tick();
        idle();
        tick();
        tick();

        // Five more collisions saturate the 2-bit counter
        rd_hit = 10'h003; valid_rd = 1'b1;
        repeat (5) tick();
        idle();
        tick();
        tick();

        // Clear coincident with a new collision on each pipeline depth
        rd_hit = 10'h0C0; valid_rd = 1'b1; err_clr = 1'b1;
        tick();
        idle();
        err_clr = 1'b1;
        tick();
        idle();
        tick();
        err_clr = 1'b1;
        tick();
        idle();
        tick();

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            rand_data();
            valid_rd = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rd_hit = '0;
                3:       rd_hit = NS'($urandom);
                default: rd_hit = NS'(1) << $urandom_range(0, NS - 1);
            endcase
            err_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();
        tick();

        // Reset while a read is in flight
        rand_data();
        rd_hit = 10'h004; valid_rd = 1'b1;
        tick();
        idle();
        #2;
        hreset = 1'b1;
        model_clear();
        #1;
        check_all();
        @(negedge hclk);
        hreset = 1'b0;
        repeat (3) tick();

        // Highest source, lone member of the partial group
        rand_data();
        rdata[9*DW +: DW] = 32'hDEAD_BEEF;
        rd_hit = 10'h200; valid_rd = 1'b1;
        tick();
        rd_hit = 10'h3FF;
        tick();
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
